// File: rtl/sobel_top.sv
// Sobel edge-detection engine over a fixed on-chip test image img[r][c] = r*c.
// Scans interior pixels in raster order, one registered |Gx|+|Gy| result per clock.
module sobel_top #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    output logic [2:0]            out_row,
    output logic [2:0]            out_col,
    output logic [DATA_WIDTH+2:0] sobel_out,
    output logic [1:0]            dbg_state
);
    localparam int SW = DATA_WIDTH + 3;
    localparam logic [2:0] LAST_ROW = 3'(IMG_HEIGHT - 2);
    localparam logic [2:0] LAST_COL = 3'(IMG_WIDTH - 2);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    typedef logic signed [SW-1:0] sval_t;

    state_t          state_q, state_d;
    logic [2:0]      row_q, row_d, col_q, col_d;
    logic [2:0]      orow_q, orow_d, ocol_q, ocol_d;
    logic [SW-1:0]   sob_q, sob_d;
    logic            done_q, done_d;

    logic [DATA_WIDTH-1:0] img [IMG_HEIGHT][IMG_WIDTH];

    for (genvar r = 0; r < IMG_HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < IMG_WIDTH; c++) begin : g_col
            assign img[r][c] = DATA_WIDTH'(r * c);
        end
    end

    function automatic sval_t ext(input logic [DATA_WIDTH-1:0] p);
        return sval_t'({3'b000, p});
    endfunction

    logic [2:0]    rm, rp, cm, cp;
    sval_t         gx, gy;
    logic [SW-1:0] ax, ay, sum;

    assign rm = row_q - 3'd1;
    assign rp = row_q + 3'd1;
    assign cm = col_q - 3'd1;
    assign cp = col_q + 3'd1;

    // Right column minus left column, bottom row minus top row.
    assign gx = (ext(img[rm][cp]) + (ext(img[row_q][cp]) <<< 1) + ext(img[rp][cp]))
              - (ext(img[rm][cm]) + (ext(img[row_q][cm]) <<< 1) + ext(img[rp][cm]));
    assign gy = (ext(img[rp][cm]) + (ext(img[rp][col_q]) <<< 1) + ext(img[rp][cp]))
              - (ext(img[rm][cm]) + (ext(img[rm][col_q]) <<< 1) + ext(img[rm][cp]));
    assign ax  = gx[SW-1] ? SW'(-gx) : SW'(gx);
    assign ay  = gy[SW-1] ? SW'(-gy) : SW'(gy);
    assign sum = ax + ay;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        sob_d   = sob_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = 3'd1;
                    col_d   = 3'd1;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                orow_d = row_q;
                ocol_d = col_q;
                sob_d  = sum;
                if (row_q == LAST_ROW && col_q == LAST_COL) begin
                    state_d = DONE;
                    row_d   = 3'd1;
                    col_d   = 3'd1;
                end else if (col_q == LAST_COL) begin
                    col_d = 3'd1;
                    row_d = row_q + 3'd1;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            DONE: begin
                // done rises one edge after the last result is registered.
                if (start) begin
                    state_d = RUN;
                    row_d   = 3'd1;
                    col_d   = 3'd1;
                    done_d  = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= 3'd1;
            col_q   <= 3'd1;
            orow_q  <= 3'd0;
            ocol_q  <= 3'd0;
            sob_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            sob_q   <= sob_d;
            done_q  <= done_d;
        end
    end

    assign done      = done_q;
    assign out_row   = orow_q;
    assign out_col   = ocol_q;
    assign sobel_out = sob_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_sobel_top.sv
// Directed bench for sobel_top: reset, full scans, restart, mid-scan reset.
module tb_sobel_top;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DW = 8;
    localparam int SW = DW + 3;
    localparam int N  = (H - 2) * (W - 2);
    localparam int PW = 6 + SW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          done;
    logic [2:0]    out_row, out_col;
    logic [SW-1:0] sobel_out;
    logic [1:0]    dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] last_exp;

    sobel_top #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .out_row(out_row), .out_col(out_col), .sobel_out(sobel_out),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic int pix(input int r, input int c);
        return (r * c) % (1 << DW);
    endfunction

    function automatic int sob(input int r, input int c);
        int gx, gy;
        gx = (pix(r-1, c+1) + 2 * pix(r, c+1) + pix(r+1, c+1))
           - (pix(r-1, c-1) + 2 * pix(r, c-1) + pix(r+1, c-1));
        gy = (pix(r+1, c-1) + 2 * pix(r+1, c) + pix(r+1, c+1))
           - (pix(r-1, c-1) + 2 * pix(r-1, c) + pix(r-1, c+1));
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Pushes all expected results, then compares one per cycle; start is held for
    // start_len edges, and optional stray pulses are sent while the scan runs.
    task automatic do_scan(input int start_len, input bit poke_run);
        logic [PW-1:0] e;
        for (int r = 1; r <= H - 2; r++)
            for (int c = 1; c <= W - 2; c++)
                exp_q.push_back({3'(r), 3'(c), SW'(sob(r, c))});
        start = 1'b1;
        @(negedge clk);
        check("done_low_after_start", {31'd0, done}, 32'd0);
        start = (start_len > 1);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            last_exp = e;
            check("result", {15'd0, out_row, out_col, sobel_out}, {15'd0, e});
            if (i == 0 || i == N - 1) check("done_during_run", {31'd0, done}, 32'd0);
            start = (i + 2 < start_len) || (poke_run && i < N - 2 && (i == 5 || i == 20));
        end
        start = 1'b0;
        check("queue_drained", exp_q.size(), 32'd0);
        @(negedge clk);
        check("done_rise", {31'd0, done}, 32'd1);
        check("state_done", {30'd0, dbg_state}, 32'd2);
        @(negedge clk);
        check("done_held", {31'd0, done}, 32'd1);
        check("hold_result", {15'd0, out_row, out_col, sobel_out}, {15'd0, last_exp});
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_row", {29'd0, out_row}, 32'd0);
        check("rst_col", {29'd0, out_col}, 32'd0);
        check("rst_sobel", {21'd0, sobel_out}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_state", {30'd0, dbg_state}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_sobel", {21'd0, sobel_out}, 32'd0);

        // Known values for the default image: S(r,c) = 8*(r+c).
        check("model_1_1", sob(1, 1), 32'd16);
        check("model_3_5", sob(3, 5), 32'd64);
        check("model_6_6", sob(6, 6), 32'd96);

        do_scan(1, 1'b0);
        check("final_row", {29'd0, out_row}, 32'd6);
        check("final_col", {29'd0, out_col}, 32'd6);
        check("final_val", {21'd0, sobel_out}, 32'd96);

        // Restart from DONE with stray start pulses during RUN.
        do_scan(1, 1'b1);

        // Mid-scan reset when (3,2) is on the outputs.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 14; i++) @(negedge clk);
        check("pre_rst_row", {29'd0, out_row}, 32'd3);
        check("pre_rst_col", {29'd0, out_col}, 32'd2);
        check("pre_rst_val", {21'd0, sobel_out}, 32'(sob(3, 2)));
        rst = 1'b1;
        #1;
        check("async_rst_row", {29'd0, out_row}, 32'd0);
        check("async_rst_col", {29'd0, out_col}, 32'd0);
        check("async_rst_val", {21'd0, sobel_out}, 32'd0);
        check("async_rst_state", {30'd0, dbg_state}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_idle", {30'd0, dbg_state}, 32'd0);
        check("post_rst_sobel", {21'd0, sobel_out}, 32'd0);
        check("post_rst_done", {31'd0, done}, 32'd0);

        // Multi-cycle start in IDLE launches a single scan.
        do_scan(3, 1'b0);
        repeat (3) @(negedge clk);
        check("stays_done", {31'd0, done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
